// File: rtl/phy_pkg.sv
// Shared constants for the PHY receive lane: comma symbol and aligner state codes.
package phy_pkg;

    // Idle/comma symbol the transmitter sends whenever it has no payload.
    localparam logic [7:0] COM_SYMBOL = 8'hBC;

    // Aligner state encoding, kept as plain 2-bit constants for older tools.
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t ST_HUNT   = 2'd0;
    localparam rx_state_t ST_ALIGN  = 2'd1;
    localparam rx_state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/phy_rx_comma_aligner.sv
// Finds byte boundaries in the serial stream using COM symbols and, once
// SYNC_COUNT boundary-aligned COMs have been seen in a row, strobes out
// each received byte on its boundary.
module phy_rx_comma_aligner
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM        = COM_SYMBOL,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       is_com,
    output logic       locked,
    output rx_state_t  state
);

    localparam logic [3:0] SYNC_LIM = 4'(SYNC_COUNT);

    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic [7:0] byte_next;
    logic       next_is_com;
    logic       boundary;

    // The byte completed by the bit arriving this cycle.
    assign byte_next   = {sr[6:0], serial_in};
    assign next_is_com = (byte_next == COM);
    assign boundary    = (bit_cnt == 3'd7);

    assign rx_byte  = byte_next;
    assign is_com   = next_is_com;
    assign byte_stb = (state == ST_LOCKED) && boundary;
    assign locked   = (state == ST_LOCKED);

    // Shift register, bit phase counter, COM run counter and alignment FSM.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr      <= 8'd0;
            bit_cnt <= 3'd0;
            com_cnt <= 4'd0;
            state   <= ST_HUNT;
        end else begin
            sr <= byte_next;
            case (state)
                ST_HUNT: begin
                    // Any bit position may start a byte; the matching COM defines the boundary.
                    if (next_is_com) begin
                        bit_cnt <= 3'd0;
                        com_cnt <= 4'd1;
                        state   <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (next_is_com) begin
                            com_cnt <= com_cnt + 4'd1;
                            if (com_cnt + 4'd1 == SYNC_LIM) begin
                                state <= ST_LOCKED;
                            end
                        end else begin
                            com_cnt <= 4'd0;
                            state   <= ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Lock is held until reset; only the bit phase keeps moving.
                    bit_cnt <= bit_cnt + 3'd1;
                end
                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: rtl/phy_rx_word_assembler.sv
// Receive lane word assembler: aligns to COM symbols, then packs four
// non-COM bytes into a 32-bit word, first byte in the top lane.
// Interface: valid_out is a one-cycle strobe with no back-pressure; data_out
// is meaningful in the cycle valid_out is high and holds until the next word.
module phy_rx_word_assembler
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM        = COM_SYMBOL,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        serial_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        sync_locked,
    output logic        err_partial,
    output logic [1:0]  rx_state
);

    logic [7:0]  rx_byte;
    logic        byte_stb;
    logic        is_com;
    logic        locked;
    rx_state_t   state;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;

    phy_rx_comma_aligner #(
        .COM        (COM),
        .SYNC_COUNT (SYNC_COUNT)
    ) u_aligner (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .serial_in (serial_in),
        .rx_byte   (rx_byte),
        .byte_stb  (byte_stb),
        .is_com    (is_com),
        .locked    (locked),
        .state     (state)
    );

    assign sync_locked = locked;
    assign rx_state    = state;

    // Collect payload bytes into lanes and publish each completed word.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            data_out    <= 32'd0;
            valid_out   <= 1'b0;
            err_partial <= 1'b0;
            byte_idx    <= 2'd0;
            word_buf    <= 24'd0;
        end else begin
            valid_out   <= 1'b0;
            err_partial <= 1'b0;
            if (byte_stb) begin
                if (is_com) begin
                    // Idle symbol: a half-built word cannot be completed, so drop it.
                    if (byte_idx != 2'd0) begin
                        err_partial <= 1'b1;
                    end
                    byte_idx <= 2'd0;
                end else begin
                    case (byte_idx)
                        2'd0:    word_buf[23:16] <= rx_byte;
                        2'd1:    word_buf[15:8]  <= rx_byte;
                        2'd2:    word_buf[7:0]   <= rx_byte;
                        default: begin
                            data_out  <= {word_buf, rx_byte};
                            valid_out <= 1'b1;
                        end
                    endcase
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_word_assembler.sv
// Bench for phy_rx_word_assembler: byte-level reference model of lock
// acquisition and word packing, checked after every transmitted byte.
module tb_phy_rx_word_assembler;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         SYNC = 4;

    logic        clk_32f;
    logic        reset;
    logic        serial_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        sync_locked;
    logic        err_partial;
    logic [1:0]  rx_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (byte level, bench knows its own alignment).
    logic        m_locked;
    int          m_com_run;
    int          m_idx;
    logic [7:0]  m_buf [4];
    logic [31:0] m_last_word;
    logic [31:0] exp_q [$];
    int          n_words_exp = 0;
    int          n_err_exp   = 0;

    // Pulse monitor state.
    int   n_valid_seen = 0;
    int   n_err_seen   = 0;
    logic prev_valid   = 1'b0;

    phy_rx_word_assembler #(
        .COM        (COM),
        .SYNC_COUNT (SYNC)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .sync_locked (sync_locked),
        .err_partial (err_partial),
        .rx_state    (rx_state)
    );

    // Clock.
    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_com_run   = 0;
        m_idx       = 0;
        m_last_word = 32'd0;
        exp_q.delete();
    endtask

    // Expected effect of one whole byte on lock, words and partial-drop errors.
    task automatic model_byte(input logic [7:0] b, output logic exp_err);
        exp_err = 1'b0;
        if (!m_locked) begin
            if (b == COM) begin
                m_com_run++;
                if (m_com_run == SYNC) m_locked = 1'b1;
            end else begin
                m_com_run = 0;
            end
        end else if (b == COM) begin
            if (m_idx != 0) begin
                exp_err = 1'b1;
                n_err_exp++;
            end
            m_idx = 0;
        end else begin
            m_buf[m_idx] = b;
            m_idx++;
            if (m_idx == 4) begin
                exp_q.push_back({m_buf[0], m_buf[1], m_buf[2], m_buf[3]});
                n_words_exp++;
                m_idx = 0;
            end
        end
    endtask

    // Driver: entered on a negedge; drives MSB first, checks right after the last bit's edge.
    task automatic send_byte(input logic [7:0] b);
        logic        e;
        logic [7:0]  bb;
        logic [31:0] w;
        bb = b;
        for (int i = 7; i >= 0; i--) begin
            serial_in = bb[i];
            @(negedge clk_32f);
        end
        model_byte(b, e);
        chk("sync_locked", {31'd0, sync_locked}, {31'd0, m_locked});
        chk("err_partial", {31'd0, err_partial}, {31'd0, e});
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("valid_out", {31'd0, valid_out}, 32'd1);
            chk("data_out", data_out, w);
            m_last_word = w;
        end else begin
            chk("valid_out", {31'd0, valid_out}, 32'd0);
            chk("data_hold", data_out, m_last_word);
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            @(negedge clk_32f);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            serial_in = 1'($urandom_range(0, 1));
            @(negedge clk_32f);
            chk("rst_data", data_out, 32'd0);
            chk("rst_valid", {31'd0, valid_out}, 32'd0);
            chk("rst_locked", {31'd0, sync_locked}, 32'd0);
            chk("rst_err", {31'd0, err_partial}, 32'd0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic chk_counts();
        chk("n_valid", n_valid_seen, n_words_exp);
        chk("n_err", n_err_seen, n_err_exp);
    endtask

    function automatic logic [7:0] rand_payload();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == COM) b = 8'h3C;
        return b;
    endfunction

    // Monitor: counts strobes between byte checks and rejects back-to-back words.
    always @(posedge clk_32f) begin
        #1;
        if (valid_out) n_valid_seen++;
        if (err_partial) n_err_seen++;
        if (!reset) chk("no_b2b_valid", {31'd0, valid_out & prev_valid}, 32'd0);
        prev_valid = valid_out;
    end

    // Stimulus.
    initial begin
        logic [7:0] t3 [4];
        logic [7:0] t5 [7];
        logic [7:0] noc [3];
        t3  = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
        t5  = '{8'hAA, 8'hBB, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h04};
        noc = '{8'h00, 8'hFF, 8'h11};
        reset     = 1'b1;
        serial_in = 1'b0;
        model_reset();

        // 1: reset with random serial input.
        do_reset(4);

        // 2: three stray bits, then four COMs lock on the last COM boundary.
        send_bits(3);
        for (int i = 0; i < SYNC; i++) send_byte(COM);

        // 3: four words of repeated bytes.
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++) send_byte(t3[w]);
        chk_counts();

        // 4: broken COM run does not lock; a full run does.
        do_reset(4);
        for (int i = 0; i < 3; i++) send_byte(COM);
        send_byte(8'h12);
        for (int i = 0; i < SYNC; i++) send_byte(COM);

        // 5: COM mid-word drops the partial word, next word is intact.
        for (int i = 0; i < 7; i++) send_byte(t5[i]);
        chk_counts();

        // Random payload with occasional idles while locked.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) send_byte(COM);
            else send_byte(rand_payload());
        end
        chk_counts();

        // 6: reset mid-word, COM-free stream stays unlocked, then relock.
        send_byte(8'h33);
        send_byte(8'h44);
        do_reset(4);
        for (int i = 0; i < 8; i++) send_byte(noc[$urandom_range(0, 2)]);
        for (int i = 0; i < SYNC; i++) send_byte(COM);
        for (int i = 0; i < 4; i++) send_byte(rand_payload());
        chk_counts();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
